cf_util_fifo_th: RTL and testbench

Parametrised synchronous FIFO, the next generation of the utility FIFO.
- Adds full-range occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags, and a selectable first-word-fall-through (FWFT) read mode.
- Buffers between IP register interfaces and streaming engines (UART/SPI TX/RX) in the utility layer.
- Single clock domain.

---
 rtl/cf_util_fifo_pkg.sv | 23 ++
 rtl/cf_util_fifo_mem.sv | 30 +++
 rtl/cf_util_fifo_th.sv | 135 +++++++++++++
 tb/tb_cf_util_fifo_th.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/cf_util_fifo_pkg.sv
// Shared helpers for the utility FIFO family: depth derivation, pointer increment, level update op.
package cf_util_fifo_pkg;

    localparam int MAX_AW = 16;

    typedef enum logic [1:0] {
        LVL_HOLD = 2'd0,
        LVL_INC  = 2'd1,
        LVL_DEC  = 2'd2
    } lvl_op_e;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    // Wraps at 2**aw so callers can use any pointer width up to MAX_AW.
    function automatic logic [MAX_AW-1:0] ptr_inc(input logic [MAX_AW-1:0] ptr, input int aw);
        logic [MAX_AW-1:0] mask;
        mask = '1 >> (MAX_AW - aw);
        return (ptr + 1'b1) & mask;
    endfunction

endpackage

// File: rtl/cf_util_fifo_mem.sv
// FIFO storage: DEPTH x DW array, synchronous write, asynchronous read, no reset.
// Latency: write visible on read port the cycle after the write edge.
// Backpressure: none; the owner gates the write enable.
module cf_util_fifo_mem
    import cf_util_fifo_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = depth_of(AW);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cf_util_fifo_th.sv
// Synchronous FIFO with occupancy count, almost-full/empty thresholds, sticky errors, optional FWFT.
// Latency: FWFT=0 rdata one cycle after rd; FWFT=1 head word combinational on rdata.
// Backpressure: writes on full are dropped (overflow) unless a read frees a slot the same cycle.
module cf_util_fifo_th
    import cf_util_fifo_pkg::*;
#(
    parameter int DW   = 8,
    parameter int AW   = 4,
    parameter bit FWFT = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [DW-1:0] wdata,
    input  logic          rd,
    input  logic          flush,
    input  logic [AW:0]   af_th,
    input  logic [AW:0]   ae_th,
    input  logic          clr_err,
    output logic [DW-1:0] rdata,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          underflow
);

    localparam int DEPTH = depth_of(AW);
    localparam int LW    = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [DW-1:0] mem_rdata;
    logic          wr_acc;
    logic          rd_acc;
    logic          ovf_set;
    logic          unf_set;
    lvl_op_e       lvl_op;

    assign empty        = (level_q == '0);
    assign full         = (level_q == LW'(DEPTH));
    assign almost_full  = (level_q >= af_th);
    assign almost_empty = (level_q <= ae_th);
    assign level        = level_q;

    // A read on full frees the slot the simultaneous write lands in.
    assign rd_acc  = !flush && rd && !empty;
    assign wr_acc  = !flush && wr && (!full || rd_acc);
    assign ovf_set = !flush && wr && !wr_acc;
    assign unf_set = !flush && rd && empty;

    always_comb begin
        lvl_op = LVL_HOLD;
        if (wr_acc && !rd_acc) begin
            lvl_op = LVL_INC;
        end else if (rd_acc && !wr_acc) begin
            lvl_op = LVL_DEC;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= AW'(ptr_inc(MAX_AW'(wr_ptr), AW));
            end
            if (rd_acc) begin
                rd_ptr <= AW'(ptr_inc(MAX_AW'(rd_ptr), AW));
            end
            case (lvl_op)
                LVL_INC: level_q <= level_q + 1'b1;
                LVL_DEC: level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Set beats clear; flush freezes the flags entirely.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!flush) begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (unf_set) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    cf_util_fifo_mem #(
        .DW (DW),
        .AW (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    generate
        if (FWFT) begin : g_fwft
            assign rdata = mem_rdata;
        end else begin : g_reg
            logic [DW-1:0] rdata_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else if (rd_acc) begin
                    rdata_q <= mem_rdata;
                end
            end
            assign rdata = rdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_cf_util_fifo_th.sv
// Directed bench for cf_util_fifo_th: registered and FWFT instances share stimulus, queue scoreboard.
module tb_cf_util_fifo_th;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] wdata = '0;
    logic       rd = 1'b0;
    logic       flush = 1'b0;
    logic [4:0] af_th = 5'd0;
    logic [4:0] ae_th = 5'd0;
    logic       clr_err = 1'b0;

    logic [7:0] rdata0, rdata1;
    logic       empty0, full0, af0, ae0, ovf0, unf0;
    logic       empty1, full1, af1, ae1, ovf1, unf1;
    logic [4:0] level0, level1;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] sb[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    logic [7:0] m_rdata = '0;

    always #5 clk = ~clk;

    cf_util_fifo_th #(.DW(8), .AW(4), .FWFT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr(wr), .wdata(wdata), .rd(rd), .flush(flush),
        .af_th(af_th), .ae_th(ae_th), .clr_err(clr_err), .rdata(rdata0),
        .empty(empty0), .full(full0), .almost_full(af0), .almost_empty(ae0),
        .level(level0), .overflow(ovf0), .underflow(unf0)
    );

    cf_util_fifo_th #(.DW(8), .AW(4), .FWFT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr(wr), .wdata(wdata), .rd(rd), .flush(flush),
        .af_th(af_th), .ae_th(ae_th), .clr_err(clr_err), .rdata(rdata1),
        .empty(empty1), .full(full1), .almost_full(af1), .almost_empty(ae1),
        .level(level1), .overflow(ovf1), .underflow(unf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check FWFT head before the edge, check state after it.
    task automatic cyc(input logic r_n, input logic w, input logic [7:0] d,
                       input logic r, input logic f, input logic c);
        int         lvl;
        logic       racc, wacc, m_full;
        @(negedge clk);
        rst_n = r_n; wr = w; wdata = d; rd = r; flush = f; clr_err = c;
        #1;
        if (r_n && sb.size() > 0) begin
            chk("fwft_head", 32'(rdata1), 32'(sb[0]));
        end
        m_full = (sb.size() == 16);
        racc   = !f && r && (sb.size() > 0);
        wacc   = !f && w && (!m_full || racc);
        @(posedge clk);
        #1;
        if (!r_n) begin
            sb.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_rdata = '0;
        end else if (f) begin
            sb.delete();
        end else begin
            if (w && !wacc) m_ovf = 1'b1;
            else if (c) m_ovf = 1'b0;
            if (r && !racc) m_unf = 1'b1;
            else if (c) m_unf = 1'b0;
            if (racc) m_rdata = sb.pop_front();
            if (wacc) sb.push_back(d);
        end
        lvl = sb.size();
        chk("level",        32'(level0), 32'(lvl));
        chk("level_fwft",   32'(level1), 32'(lvl));
        chk("empty",        32'(empty0), 32'(lvl == 0));
        chk("full",         32'(full0),  32'(lvl == 16));
        chk("almost_full",  32'(af0),    32'(lvl >= int'(af_th)));
        chk("almost_empty", 32'(ae0),    32'(lvl <= int'(ae_th)));
        chk("overflow",     32'(ovf0),   32'(m_ovf));
        chk("underflow",    32'(unf0),   32'(m_unf));
        chk("rdata_reg",    32'(rdata0), 32'(m_rdata));
    endtask

    initial begin
        // Reset with af_th=0: almost_full must read 1 while empty.
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        af_th = 5'd14;
        ae_th = 5'd2;

        // Fill 0x01..0x10, then one write too many.
        for (int i = 1; i <= 17; i++) cyc(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        // Drain all 16, then read on empty.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // FWFT head visibility.
        cyc(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Full with concurrent read/write across pointer wrap.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 8'(8'h80 + i), 1'b1, 1'b0, 1'b0);
        af_th = 5'd17;
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        af_th = 5'd14;

        // Read+write on empty, then clear racing a fresh underflow.
        cyc(1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Flush at level 9 with a write pending.
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 8'h71, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Reset mid-stream.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 8'(8'hD0 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
